// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared widths, types and helpers for the common-data-bus arbiter
// Purpose: one place for the result/tag widths and the per-FU holding entry layout.
// Ports: none (package).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package cdb_pkg;

    localparam int XLEN        = `XLEN;
    localparam int ROB_TAG_LEN = `ROB_TAG_LEN;

    // One buffered FU result waiting for its broadcast slot.
    typedef struct packed {
        logic                    valid;
        logic [`XLEN-1:0]        value;
        logic [`ROB_TAG_LEN-1:0] tag;
    } cdb_entry_t;

    // Broadcast qualifier driven toward the ROB.
    typedef struct packed {
        logic                    flag;
        logic [`ROB_TAG_LEN-1:0] tag;
    } cdb_sel_t;

    // Modulo-n increment with an explicit compare so non-power-of-2 counts wrap correctly.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker over a request vector
// Purpose: return the first requester found when scanning ptr, ptr+1, ... modulo N.
// Ports:
//   req       in  N  request per slot
//   ptr       in  W  slot with highest priority this cycle (must be < N)
//   gnt_valid out 1  at least one request present
//   gnt_idx   out W  index of the winning slot (0 when no request)
module rr_picker #(
    parameter int  N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [31:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        // Scan from the farthest slot back toward ptr; the last hit is the nearest requester.
        for (int k = N - 1; k >= 0; k--) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= 32'(N)) begin
                idx = idx - 32'(N);
            end
            if (req[idx[W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result buffering and round-robin CDB broadcast select
// Purpose: hold one completed result per FU, pick one per cycle by round-robin, back-pressure FUs.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   fu_valid/fu_value/fu_rob_tag/fu_ready   per-FU result handshake
//   flush          drop all buffered results, no broadcast this cycle
//   cdb_stall      ROB cannot accept a broadcast this cycle
//   select_flag/select_signal/rob_tag       broadcast qualifier and index
//   out_values     buffered value per FU for the downstream CDB mux
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int  FU_NUM = 4,
    localparam int SEL_W  = $clog2(FU_NUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FU_NUM-1:0]                 fu_valid,
    input  logic [FU_NUM-1:0][XLEN-1:0]       fu_value,
    input  logic [FU_NUM-1:0][ROB_TAG_LEN-1:0] fu_rob_tag,
    output logic [FU_NUM-1:0]                 fu_ready,
    input  logic                              flush,
    input  logic                              cdb_stall,
    output logic                              select_flag,
    output logic [SEL_W-1:0]                  select_signal,
    output logic [ROB_TAG_LEN-1:0]            rob_tag,
    output logic [FU_NUM-1:0][XLEN-1:0]       out_values
);

    cdb_entry_t        hold [FU_NUM];
    logic [SEL_W-1:0]  rr_ptr;
    logic [FU_NUM-1:0] hv;
    logic [FU_NUM-1:0] gnt_onehot;
    logic              pick_valid;
    logic [SEL_W-1:0]  pick_idx;
    logic              grant;
    cdb_sel_t          bcast;

    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            hv[i]         = hold[i].valid;
            out_values[i] = hold[i].value;
        end
    end

    rr_picker #(.N(FU_NUM)) u_picker (
        .req       (hv),
        .ptr       (rr_ptr),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Stall and flush only mask the grant; the pick itself comes from registered state.
    assign grant = pick_valid & ~cdb_stall & ~flush;

    always_comb begin
        gnt_onehot = '0;
        if (grant) begin
            gnt_onehot[pick_idx] = 1'b1;
        end
    end

    // A slot being granted can take its next result on the same edge it drains.
    assign fu_ready = ~{FU_NUM{flush}} & (~hv | gnt_onehot);

    always_comb begin
        bcast.flag = grant;
        bcast.tag  = grant ? hold[pick_idx].tag : '0;
    end

    assign select_flag   = bcast.flag;
    assign rob_tag       = bcast.tag;
    assign select_signal = grant ? pick_idx : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FU_NUM; i++) begin
                hold[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (flush) begin
                    hold[i].valid <= 1'b0;
                end else if (fu_valid[i] && fu_ready[i]) begin
                    hold[i].valid <= 1'b1;
                    hold[i].value <= fu_value[i];
                    hold[i].tag   <= fu_rob_tag[i];
                end else if (gnt_onehot[i]) begin
                    hold[i].valid <= 1'b0;
                end
            end
            if (grant) begin
                rr_ptr <= SEL_W'(rr_wrap_inc(32'(pick_idx), FU_NUM));
            end
        end
    end

    a_sel_holds_entry: assert property (@(posedge clk) disable iff (!rst_n)
        select_flag |-> hv[select_signal]);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a behavioural model
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NF = 4;

    logic                          clk;
    logic                          rst_n;
    logic [NF-1:0]                 fu_valid;
    logic [NF-1:0][XLEN-1:0]       fu_value;
    logic [NF-1:0][ROB_TAG_LEN-1:0] fu_rob_tag;
    logic [NF-1:0]                 fu_ready;
    logic                          flush;
    logic                          cdb_stall;
    logic                          select_flag;
    logic [1:0]                    select_signal;
    logic [ROB_TAG_LEN-1:0]        rob_tag;
    logic [NF-1:0][XLEN-1:0]       out_values;

    cdb_arbiter #(.FU_NUM(NF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fu_valid      (fu_valid),
        .fu_value      (fu_value),
        .fu_rob_tag    (fu_rob_tag),
        .fu_ready      (fu_ready),
        .flush         (flush),
        .cdb_stall     (cdb_stall),
        .select_flag   (select_flag),
        .select_signal (select_signal),
        .rob_tag       (rob_tag),
        .out_values    (out_values)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit                     m_hv  [NF];
    logic [XLEN-1:0]        m_val [NF];
    logic [ROB_TAG_LEN-1:0] m_tag [NF];
    int                     m_ptr;

    // Model predictions for the current cycle
    bit                      e_flag;
    int                      e_idx;
    logic [ROB_TAG_LEN-1:0]  e_tag;
    logic [NF-1:0]           e_ready;
    logic [NF-1:0][XLEN-1:0] e_vals;

    // Winner = held entry with the smallest forward distance from the pointer.
    function automatic void model_eval();
        int best, bestd, d;
        best  = -1;
        bestd = NF;
        for (int i = 0; i < NF; i++) begin
            if (m_hv[i]) begin
                d = (i - m_ptr + NF) % NF;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        e_flag = (best >= 0) && !cdb_stall && !flush;
        e_idx  = e_flag ? best : 0;
        e_tag  = e_flag ? m_tag[best] : '0;
        for (int i = 0; i < NF; i++) begin
            e_ready[i] = !flush && (!m_hv[i] || (e_flag && best == i));
            e_vals[i]  = m_val[i];
        end
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            for (int i = 0; i < NF; i++) begin
                m_hv[i]  = 0;
                m_val[i] = '0;
                m_tag[i] = '0;
            end
            m_ptr = 0;
        end else begin
            model_eval();
            for (int i = 0; i < NF; i++) begin
                if (flush) m_hv[i] = 0;
                else if (fu_valid[i] && e_ready[i]) begin
                    m_hv[i]  = 1;
                    m_val[i] = fu_value[i];
                    m_tag[i] = fu_rob_tag[i];
                end else if (e_flag && e_idx == i) m_hv[i] = 0;
            end
            if (e_flag) m_ptr = (e_idx + 1) % NF;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        fu_valid  = '0;
        flush     = 1'b0;
        cdb_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        fu_valid = 4'(($urandom()));
        for (int i = 0; i < NF; i++) begin
            fu_value[i]   = XLEN'($urandom());
            fu_rob_tag[i] = ROB_TAG_LEN'($urandom());
        end
        flush = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        set_idle();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if ({select_flag, select_signal, rob_tag, fu_ready} !== {1'b0, 2'd0, ROB_TAG_LEN'(0), 4'hF}) begin
                n_bad++;
                $display("FAIL reset_idle c%0d: flag/sel/tag/ready=%b/%0d/%0d/%b want 0/0/0/1111",
                         c, select_flag, select_signal, rob_tag, fu_ready);
            end
            n_cmp++;
            if (out_values !== '0) begin
                n_bad++;
                $display("FAIL reset_values c%0d: got %h want 0", c, out_values);
            end
            tick();
        end
    endtask

    task automatic test_single();
        fu_valid      = 4'b0100;
        fu_value[2]   = XLEN'(32'hDEAD_BEEF);
        fu_rob_tag[2] = ROB_TAG_LEN'(5);
        tick();
        set_idle();
        #1;
        n_cmp++;
        if (select_flag !== 1'b1 || select_signal !== 2'd2 || rob_tag !== ROB_TAG_LEN'(5)
            || out_values[2] !== XLEN'(32'hDEAD_BEEF)) begin
            n_bad++;
            $display("FAIL single_bcast: flag/sel/tag/val=%b/%0d/%0d/%h want 1/2/5/deadbeef",
                     select_flag, select_signal, rob_tag, out_values[2]);
        end
        tick();
        #1;
        n_cmp++;
        if (select_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: flag=%b want 0", select_flag);
        end
        tick();
    endtask

    task automatic test_all_valid();
        int s;
        do_reset();
        fu_valid = 4'hF;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < NF; i++) begin
                fu_value[i]   = XLEN'($urandom());
                fu_rob_tag[i] = ROB_TAG_LEN'($urandom());
            end
            #1;
            model_eval();
            if (c > 0) begin
                s = (c - 1) % NF;
                n_cmp++;
                if (select_flag !== 1'b1 || select_signal !== 2'(s) || fu_ready !== 4'(1 << s)
                    || rob_tag !== e_tag) begin
                    n_bad++;
                    $display("FAIL all_valid c%0d: flag/sel/ready/tag=%b/%0d/%b/%0d want 1/%0d/%b/%0d",
                             c, select_flag, select_signal, fu_ready, rob_tag, s, 4'(1 << s), e_tag);
                end
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_stall();
        do_reset();
        fu_valid      = 4'b0010;
        fu_rob_tag[1] = ROB_TAG_LEN'(7);
        fu_value[1]   = XLEN'($urandom());
        tick();
        set_idle();
        cdb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (select_flag !== 1'b0 || fu_ready[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall c%0d: flag/ready1=%b/%b want 0/0", c, select_flag, fu_ready[1]);
            end
            tick();
        end
        cdb_stall = 1'b0;
        #1;
        n_cmp++;
        if (select_flag !== 1'b1 || select_signal !== 2'd1 || rob_tag !== ROB_TAG_LEN'(7)) begin
            n_bad++;
            $display("FAIL stall_release: flag/sel/tag=%b/%0d/%0d want 1/1/7", select_flag, select_signal, rob_tag);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        fu_valid      = 4'b1001;
        fu_rob_tag[0] = ROB_TAG_LEN'(3);
        fu_rob_tag[3] = ROB_TAG_LEN'(4);
        tick();
        fu_valid  = 4'hF;
        flush     = 1'b1;
        cdb_stall = 1'b1;
        #1;
        n_cmp++;
        if (select_flag !== 1'b0 || fu_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL flush_cycle: flag/ready=%b/%b want 0/0000", select_flag, fu_ready);
        end
        tick();
        set_idle();
        #1;
        n_cmp++;
        if (select_flag !== 1'b0 || fu_ready !== 4'hF) begin
            n_bad++;
            $display("FAIL flush_after: flag/ready=%b/%b want 0/1111", select_flag, fu_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            fu_valid = 4'(($urandom() & 32'h7));
            for (int i = 0; i < 3; i++) begin
                fu_value[i]   = XLEN'($urandom());
                fu_rob_tag[i] = ROB_TAG_LEN'($urandom_range(20, 10));
            end
            tick();
        end
        fu_valid      = 4'b1000;
        fu_rob_tag[3] = ROB_TAG_LEN'(9);
        fu_value[3]   = XLEN'($urandom());
        cdb_stall     = 1'b1;
        tick();
        rst_n     = 1'b0;
        cdb_stall = 1'b0;
        fu_valid  = 4'hF;
        tick();
        rst_n = 1'b1;
        set_idle();
        #1;
        n_cmp++;
        if ({select_flag, select_signal, rob_tag, fu_ready} !== {1'b0, 2'd0, ROB_TAG_LEN'(0), 4'hF}
            || out_values !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: flag/sel/tag/ready=%b/%0d/%0d/%b vals=%h want 0/0/0/1111 vals=0",
                     select_flag, select_signal, rob_tag, fu_ready, out_values);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            n_cmp++;
            if (select_flag !== 1'b0 || rob_tag === ROB_TAG_LEN'(9)) begin
                n_bad++;
                $display("FAIL reset_mid_drop c%0d: flag/tag=%b/%0d want 0/0", c, select_flag, rob_tag);
            end
        end
        fu_valid = 4'hF;
        for (int i = 0; i < NF; i++) fu_rob_tag[i] = ROB_TAG_LEN'(i + 1);
        tick();
        set_idle();
        #1;
        n_cmp++;
        if (select_flag !== 1'b1 || select_signal !== 2'd0 || rob_tag !== ROB_TAG_LEN'(1)) begin
            n_bad++;
            $display("FAIL reset_mid_ptr: flag/sel/tag=%b/%0d/%0d want 1/0/1", select_flag, select_signal, rob_tag);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(99) != 0);
            flush     = ($urandom_range(19) == 0);
            cdb_stall = ($urandom_range(3) == 0);
            fu_valid  = 4'($urandom());
            for (int i = 0; i < NF; i++) begin
                fu_value[i]   = XLEN'($urandom());
                fu_rob_tag[i] = ROB_TAG_LEN'($urandom());
            end
            #1;
            model_eval();
            n_cmp++;
            if ({select_flag, select_signal, rob_tag, fu_ready} !== {e_flag, e_idx[1:0], e_tag, e_ready}) begin
                n_bad++;
                $display("FAIL random_ctrl c%0d: flag/sel/tag/ready=%b/%0d/%0d/%b want %b/%0d/%0d/%b",
                         c, select_flag, select_signal, rob_tag, fu_ready, e_flag, e_idx, e_tag, e_ready);
            end
            n_cmp++;
            if (out_values !== e_vals) begin
                n_bad++;
                $display("FAIL random_vals c%0d: got %h want %h", c, out_values, e_vals);
            end
            tick();
        end
        rst_n = 1'b1;
        set_idle();
    endtask

    initial begin
        rst_n      = 1'b0;
        fu_valid   = '0;
        fu_value   = '0;
        fu_rob_tag = '0;
        flush      = 1'b0;
        cdb_stall  = 1'b0;
        for (int i = 0; i < NF; i++) begin
            m_hv[i]  = 0;
            m_val[i] = '0;
            m_tag[i] = '0;
        end
        m_ptr = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
